// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//    Multi-cycle MIPS control unit. A Moore FSM sequences each instruction
//    through fetch / decode / execute / memory / writeback over several clock
//    cycles and drives the select and enable lines of a shared-memory
//    datapath. Supported opcodes: R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ,
//    BNE, J and JAL. Memory accesses (FETCH, MEMRD, MEMWR) stall on mem_ready.
//
// Parameters:
//    ALUOP_WIDTH    width of ALUOp, ALU codes are zero-extended (>= 3)
//    USE_MEM_READY  1: memory states wait for mem_ready, 0: mem_ready ignored
//
// Ports:
//    clk         in   rising-edge clock
//    reset       in   asynchronous, active-high reset
//    OP          in   opcode from the instruction register
//    mem_ready   in   memory access completes this cycle
//    PCWrite     out  unconditional PC load
//    BranchEQ    out  PC load if ALU zero
//    BranchNE    out  PC load if ALU not zero
//    IorD        out  memory address select (0 PC, 1 ALUOut)
//    MemRead     out  memory read request
//    MemWrite    out  memory write request
//    IRWrite     out  instruction register load
//    RegDst      out  write register select (0 rt, 1 rd, 2 $31)
//    MemtoReg    out  write data select (0 ALUOut, 1 MDR, 2 PC)
//    RegWrite    out  register-file write enable
//    ALUSrcA     out  ALU A select (0 PC, 1 rs)
//    ALUSrcB     out  ALU B select (0 rt, 1 const 4, 2 imm, 3 imm<<2)
//    PCSource    out  next PC select (0 ALU, 1 ALUOut, 2 jump target)
//    ALUOp       out  ALU operation code
//    state_o     out  current state code (debug)
//    instr_done  out  one-cycle pulse in the final state of an instruction
//    illegal_op  out  one-cycle pulse in DECODE for an unsupported opcode
// ----------------------------------------------------------------------------
module multicycle_control #(
   parameter int ALUOP_WIDTH   = 3,
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             OP,
   input  logic                   mem_ready,
   output logic                   PCWrite,
   output logic                   BranchEQ,
   output logic                   BranchNE,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic [1:0]             RegDst,
   output logic [1:0]             MemtoReg,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             PCSource,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic [3:0]             state_o,
   output logic                   instr_done,
   output logic                   illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ITEXEC = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3'b000);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(3'b001);
   localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(3'b011);
   localparam logic [ALUOP_WIDTH-1:0] ALU_ADDI  = ALUOP_WIDTH'(3'b100);
   localparam logic [ALUOP_WIDTH-1:0] ALU_ORI   = ALUOP_WIDTH'(3'b101);
   localparam logic [ALUOP_WIDTH-1:0] ALU_ANDI  = ALUOP_WIDTH'(3'b110);
   localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(3'b111);

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic       mem_rdy;

   // With the handshake disabled every memory access completes in one cycle.
   assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its inputs regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // NOTE: every output and next-state signal gets a default before the case
   // statement, so no path through the block leaves a value unassigned and no
   // latch is inferred.
   always_comb begin
      state_d    = S_FETCH;
      op_d       = op_q;
      PCWrite    = 1'b0;
      BranchEQ   = 1'b0;
      BranchNE   = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 2'd0;
      MemtoReg   = 2'd0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'd0;
      PCSource   = 2'd0;
      ALUOp      = ALU_ADD;
      instr_done = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 is computed while the instruction is read.
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            IRWrite = mem_rdy;
            PCWrite = mem_rdy;
            state_d = mem_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut; the opcode is
            // captured here so later states ignore further OP changes.
            ALUSrcB = 2'd3;
            op_d    = OP;
            case (OP)
               OP_LW, OP_SW:                       state_d = S_MEMADR;
               OP_R:                               state_d = S_RTEXEC;
               OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
               OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:   state_d = S_ITEXEC;
               OP_J, OP_JAL:                       state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            state_d = (op_q == OP_LW) ? S_MEMRD :
                      (op_q == OP_SW) ? S_MEMWR : S_FETCH;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = mem_rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 2'd1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_rdy;
            state_d    = mem_rdy ? S_FETCH : S_MEMWR;
         end
         S_RTEXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
            state_d = S_ALUWB;
         end
         S_ITEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            case (op_q)
               OP_ADDI: ALUOp = ALU_ADDI;
               OP_ORI:  ALUOp = ALU_ORI;
               OP_ANDI: ALUOp = ALU_ANDI;
               OP_LUI:  ALUOp = ALU_LUI;
               default: ALUOp = ALU_ADD;
            endcase
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = (op_q == OP_R) ? 2'd1 : 2'd0;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = ALU_SUB;
            PCSource   = 2'd1;
            BranchEQ   = (op_q == OP_BEQ);
            BranchNE   = (op_q == OP_BNE);
            instr_done = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'd2;
            instr_done = 1'b1;
            // PC already holds PC+4, which is the JAL return address.
            if (op_q == OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = 2'd2;
               MemtoReg = 2'd2;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Enables are forced low while reset is held so a reset landing
      // mid-instruction cannot leak a register or memory write.
      if (reset) begin
         PCWrite    = 1'b0;
         BranchEQ   = 1'b0;
         BranchNE   = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegDst     = 2'd0;
         MemtoReg   = 2'd0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'd0;
         PCSource   = 2'd0;
         ALUOp      = ALU_ADD;
         instr_done = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. A driver plans each instruction
// as a list of (state, mem_ready) cycles derived from the instruction class,
// drives OP and mem_ready one cycle at a time, and pushes the expected output
// vector for that cycle into a queue. A monitor on the falling edge pops and
// compares against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

   typedef struct packed {
      logic       pcw;
      logic       beq;
      logic       bne;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic       regw;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic [3:0] st;
      logic       done;
      logic       ill;
   } outs_t;

   localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04,
                          BNE = 6'h05, ADDI = 6'h08, ANDI = 6'h0c,
                          ORI = 6'h0d, LUI = 6'h0f, LW = 6'h23, SW = 6'h2b;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OP;
   logic       mem_ready;
   logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic       RegWrite, ALUSrcA;
   logic [2:0] ALUOp;
   logic [3:0] state_o;
   logic       instr_done, illegal_op;

   int    vectors     = 0;
   int    miscompares = 0;
   outs_t exp_q[$];

   multicycle_control #(.ALUOP_WIDTH(3), .USE_MEM_READY(1'b1)) dut (
      .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp), .state_o(state_o), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(logic [5:0] op);
      return op inside {R, J, JAL, BEQ, BNE, ADDI, ANDI, ORI, LUI, LW, SW};
   endfunction

   // Expected outputs for one cycle, straight from the per-state table.
   function automatic outs_t exp_out(int st, logic [5:0] op, bit mr);
      outs_t o;
      o    = '0;
      o.st = st[3:0];
      case (st)
         0: begin o.mrd = 1; o.srcb = 2'd1; o.irw = mr; o.pcw = mr; end
         1: begin o.srcb = 2'd3; o.ill = !is_legal(op); end
         2: begin o.srca = 1; o.srcb = 2'd2; end
         3: begin o.mrd = 1; o.iord = 1; end
         4: begin o.regw = 1; o.memtoreg = 2'd1; o.done = 1; end
         5: begin o.mwr = 1; o.iord = 1; o.done = mr; end
         6: begin o.srca = 1; o.aluop = 3'b111; end
         7: begin
            o.srca  = 1;
            o.srcb  = 2'd2;
            o.aluop = (op == ADDI) ? 3'b100 : (op == ORI) ? 3'b101 :
                      (op == ANDI) ? 3'b110 : 3'b011;
         end
         8: begin o.regw = 1; o.regdst = (op == R) ? 2'd1 : 2'd0; o.done = 1; end
         9: begin
            o.srca = 1; o.aluop = 3'b001; o.pcsrc = 2'd1; o.done = 1;
            o.beq = (op == BEQ);
            o.bne = (op == BNE);
         end
         10: begin
            o.pcw = 1; o.pcsrc = 2'd2; o.done = 1;
            if (op == JAL) begin o.regw = 1; o.regdst = 2'd2; o.memtoreg = 2'd2; end
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic check(string name, outs_t act, outs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h (state %0d) expected %h (state %0d)",
                  name, $time, act, act.st, exp, exp.st);
      end
   endtask

   // Monitor: one comparison per queued cycle, sampled on the falling edge.
   always @(negedge clk) begin
      outs_t e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
              RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
              state_o, instr_done, illegal_op};
         check($sformatf("outs_st%0d", e.st), a, e);
      end
   end

   task automatic drive(int st, logic [5:0] op, bit mr, logic [5:0] op_in);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      OP        = op_in;
      mem_ready = mr;
      exp_q.push_back(exp_out(st, op, mr));
   endtask

   task automatic drive_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      OP        = 6'($urandom);
      mem_ready = 1'($urandom);
      exp_q.push_back('0);
   endtask

   // Plan one instruction as a cycle list, then play it. abort_at >= 0
   // replaces that cycle with a two-cycle reset pulse.
   task automatic run_instr(logic [5:0] op, int f_stall, int m_stall, int abort_at);
      int sts[$];
      bit mrs[$];
      for (int i = 0; i < f_stall; i++) begin sts.push_back(0); mrs.push_back(0); end
      sts.push_back(0); mrs.push_back(1);
      sts.push_back(1); mrs.push_back(1'($urandom));
      if (op == LW) begin
         sts.push_back(2); mrs.push_back(1'($urandom));
         for (int i = 0; i < m_stall; i++) begin sts.push_back(3); mrs.push_back(0); end
         sts.push_back(3); mrs.push_back(1);
         sts.push_back(4); mrs.push_back(1'($urandom));
      end else if (op == SW) begin
         sts.push_back(2); mrs.push_back(1'($urandom));
         for (int i = 0; i < m_stall; i++) begin sts.push_back(5); mrs.push_back(0); end
         sts.push_back(5); mrs.push_back(1);
      end else if (op == R) begin
         sts.push_back(6); mrs.push_back(1'($urandom));
         sts.push_back(8); mrs.push_back(1'($urandom));
      end else if (op inside {ADDI, ORI, ANDI, LUI}) begin
         sts.push_back(7); mrs.push_back(1'($urandom));
         sts.push_back(8); mrs.push_back(1'($urandom));
      end else if (op inside {BEQ, BNE}) begin
         sts.push_back(9); mrs.push_back(1'($urandom));
      end else if (op inside {J, JAL}) begin
         sts.push_back(10); mrs.push_back(1'($urandom));
      end
      for (int i = 0; i < sts.size(); i++) begin
         if (i == abort_at) begin
            drive_reset();
            drive_reset();
            return;
         end
         // OP only matters in DECODE; elsewhere it is scrambled.
         drive(sts[i], op, mrs[i], (sts[i] == 1) ? op : 6'($urandom));
      end
   endtask

   initial begin
      logic [5:0] legal_ops [11];
      logic [5:0] op;
      legal_ops = '{R, J, JAL, BEQ, BNE, ADDI, ANDI, ORI, LUI, LW, SW};
      reset     = 1'b1;
      OP        = 6'h00;
      mem_ready = 1'b0;
      drive_reset();
      drive_reset();

      run_instr(LW,   0, 0, -1);
      run_instr(ORI,  0, 0, -1);
      run_instr(R,    0, 0, -1);
      run_instr(LW,   3, 2, -1);
      run_instr(BNE,  0, 0, -1);
      run_instr(JAL,  0, 0, -1);
      run_instr(6'h3f, 0, 0, -1);
      run_instr(LW,   0, 3, 4);    // reset lands in MEMRD while stalled
      run_instr(SW,   1, 2, -1);
      run_instr(BEQ,  0, 0, -1);
      run_instr(J,    0, 0, -1);
      run_instr(ADDI, 0, 0, -1);
      run_instr(ANDI, 0, 0, -1);
      run_instr(LUI,  0, 0, -1);
      run_instr(LW,   0, 0, 4);    // reset lands in MEMWB
      run_instr(SW,   0, 1, 3);    // reset lands in MEMWR
      run_instr(JAL,  0, 0, 2);    // reset lands in JUMP

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 10)];
         else                          op = 6'($urandom);
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
      end

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected cycles never compared, required 0",
                  exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
